gcd_controller: RTL and testbench
=================================

// Module: gcd_controller
// PURPOSE
//  FSM that sequences the 16-bit GCD datapath (regs A/B, subtractor, muxes, comparator).
//  Accepts two operands on a valid/ready stream and steers them into A then B.
//  Runs one subtract-and-reload per cycle until A==B, then holds a result handshake.
//  The result is read from the datapath A register while out_valid=1.
// PARAMETERS
//  CNT_W     16      width of the iteration counter (iter_cnt)
//  MAX_ITER  65535   subtract-cycle limit; used only with GCD_TIMEOUT_EN; must fit CNT_W
// PORTS
//  clk        in   1      single clock, all state on rising edge
//  rst        in   1      synchronous, active-high reset
//  in_valid   in   1      operand present on datapath data_in
//  in_ready   out  1      controller accepts operand this cycle
//  out_valid  out  1      GCD available on datapath A output
//  out_ready  in   1      consumer takes result
//  busy       out  1      high from first operand accept until result handshake
//  err        out  1      timeout flag, qualified by out_valid
//  iter_cnt   out  CNT_W  subtract cycles spent on current operation
//  gt,lt,eq   in   1      comparator flags: A>B, A<B, A==B (from registered A/B)
//  ldA,ldB    out  1      load enables for datapath regs A, B
//  sel1       out  1      subtractor minuend: 1=A, 0=B
//  sel2       out  1      subtractor subtrahend: 1=A, 0=B
//  sel_in     out  1      bus source: 1=data_in, 0=subtractor output
// BEHAVIOUR
//  States: IDLE (await A), LOAD_B (await B), COMPUTE, DONE. Encoding is free.
//  Reset: while rst=1, every output is forced to 0 and iter_cnt is cleared.
//   The next cycle, the FSM is in IDLE.
//  Reset mid-operation: abandons the operation immediately and returns to IDLE.
//   No partial result is ever flagged.
//  Control outputs are combinational from state and inputs (Mealy).
//   sel* defaults to 0 wherever not specified below.
//  IDLE:
//   in_ready=1, sel_in=1, ldA=in_valid.
//   On in_valid: go to LOAD_B, clear iter_cnt.
//  LOAD_B:
//   in_ready=1, sel_in=1, ldB=in_valid.
//   On in_valid: go to COMPUTE. Otherwise hold.
//  COMPUTE (flags valid: A/B are registered one cycle earlier):
//   eq: no load; go to DONE.
//   gt: ldA=1, sel1=1, sel2=0, sel_in=0 (A<=A-B); iter_cnt++.
//   lt: ldB=1, sel1=0, sel2=1, sel_in=0 (B<=B-A); iter_cnt++.
//   Flags are mutually exclusive; if none is set (X/illegal), do nothing.
//  DONE:
//   out_valid=1, all loads 0, so A is stable.
//   On out_ready: go to IDLE. in_ready=0, so no new operand is taken in the same cycle.
//  busy=1 in LOAD_B, COMPUTE and DONE.
//  Latency: accept A -> accept B -> N subtract cycles -> 1 eq cycle -> out_valid.
//   With back-to-back in_valid, out_valid asserts 2+N+1 cycles after A is accepted.
//  out_valid holds, with result stable, for as long as out_ready=0.
//  iter_cnt saturates at all-ones; it never wraps.
//  Zero operand (A=0 or B=0, not both) never reaches eq. It hangs without the option below.
// CONFIGURATION
//  GCD_TIMEOUT_EN defined:
//   In COMPUTE, if iter_cnt==MAX_ITER and eq=0: go to DONE with err=1 and no load that cycle.
//   err is cleared on leaving DONE or on rst.
//  GCD_TIMEOUT_EN undefined:
//   No limit check; err is tied 0.
//   A zero operand stalls in COMPUTE until rst.
// TESTING
//  T1 A=48,B=18 back-to-back -> 4 subtract cycles (30,12,6,6), out_valid 7 cycles after A accept, A=6, iter_cnt=4.
//  T2 A=7,B=7 -> eq on first COMPUTE cycle, no ldA/ldB, out_valid 3 cycles after A accept, iter_cnt=0.
//  T3 A=5,B=35, in_valid low 2 cycles between operands -> LOAD_B holds, result A=5, iter_cnt=6.
//  T4 result ready, out_ready low 3 cycles -> out_valid and A stable; in_ready=0 throughout; IDLE after handshake.
//  T5 rst=1 mid-COMPUTE (A=1000,B=3) -> next cycle IDLE, all outputs 0 during rst, out_valid never asserted.
//  T6 GCD_TIMEOUT_EN, MAX_ITER=8, A=0,B=5 -> DONE after 8 subtract cycles with err=1; without macro, busy stays 1 for 200 cycles.

Source files
------------

// File: rtl/gcd_controller.sv
// Control FSM for a subtractive 16-bit GCD datapath: operand intake, subtract loop, result handshake.
// Defining GCD_TIMEOUT_EN adds an iteration limit (MAX_ITER) that ends the loop with err=1.
module gcd_controller #(
  parameter int unsigned CNT_W    = 16,
  parameter int unsigned MAX_ITER = 65535
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy,
  output logic             err,
  output logic [CNT_W-1:0] iter_cnt,
  input  logic             gt,
  input  logic             lt,
  input  logic             eq,
  output logic             ldA,
  output logic             ldB,
  output logic             sel1,
  output logic             sel2,
  output logic             sel_in
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_LOAD_B  = 2'd1,
    S_COMPUTE = 2'd2,
    S_DONE    = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic             flag_gt, flag_lt, flag_eq;
  logic             in_ready_c, out_valid_c, busy_c;
  logic             lda_c, ldb_c, sel1_c, sel2_c, sel_in_c;

  if ((longint'(MAX_ITER) >> CNT_W) != 0) begin : g_max_iter_too_wide
    $error("MAX_ITER does not fit in CNT_W bits");
  end

  // Only a single asserted flag is acted on; illegal/unknown combinations stall.
  assign flag_gt = gt & ~lt & ~eq;
  assign flag_lt = lt & ~gt & ~eq;
  assign flag_eq = eq & ~gt & ~lt;

  assign cnt_inc = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + CNT_W'(1);

`ifdef GCD_TIMEOUT_EN
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_ITER);
  logic err_q, err_d, timeout_hit;
  assign timeout_hit = (cnt_q == MAX_CNT) && !eq;
`endif

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    in_ready_c  = 1'b0;
    out_valid_c = 1'b0;
    busy_c      = 1'b0;
    lda_c       = 1'b0;
    ldb_c       = 1'b0;
    sel1_c      = 1'b0;
    sel2_c      = 1'b0;
    sel_in_c    = 1'b0;
`ifdef GCD_TIMEOUT_EN
    err_d       = err_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        in_ready_c = 1'b1;
        sel_in_c   = 1'b1;
        lda_c      = in_valid;
        if (in_valid) begin
          state_d = S_LOAD_B;
          cnt_d   = '0;
        end
      end
      S_LOAD_B: begin
        busy_c     = 1'b1;
        in_ready_c = 1'b1;
        sel_in_c   = 1'b1;
        ldb_c      = in_valid;
        if (in_valid) state_d = S_COMPUTE;
      end
      S_COMPUTE: begin
        busy_c = 1'b1;
        if (flag_eq) begin
          state_d = S_DONE;
        end
`ifdef GCD_TIMEOUT_EN
        else if (timeout_hit) begin
          state_d = S_DONE;
          err_d   = 1'b1;
        end
`endif
        else if (flag_gt) begin
          // A <= A - B
          lda_c  = 1'b1;
          sel1_c = 1'b1;
          cnt_d  = cnt_inc;
        end else if (flag_lt) begin
          // B <= B - A
          ldb_c  = 1'b1;
          sel2_c = 1'b1;
          cnt_d  = cnt_inc;
        end
      end
      S_DONE: begin
        busy_c      = 1'b1;
        out_valid_c = 1'b1;
        if (out_ready) begin
          state_d = S_IDLE;
`ifdef GCD_TIMEOUT_EN
          err_d   = 1'b0;
`endif
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

`ifdef GCD_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (rst) err_q <= 1'b0;
    else     err_q <= err_d;
  end
`endif

  // Reset masks every output combinationally, so nothing leaks during the rst cycle.
  assign in_ready  = in_ready_c  & ~rst;
  assign out_valid = out_valid_c & ~rst;
  assign busy      = busy_c      & ~rst;
  assign ldA       = lda_c       & ~rst;
  assign ldB       = ldb_c       & ~rst;
  assign sel1      = sel1_c      & ~rst;
  assign sel2      = sel2_c      & ~rst;
  assign sel_in    = sel_in_c    & ~rst;
  assign iter_cnt  = rst ? '0 : cnt_q;

`ifdef GCD_TIMEOUT_EN
  assign err = err_q & out_valid;
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_gcd_controller.sv
// Bench for gcd_controller: drives a behavioural GCD datapath and compares against an Euclid reference.
module tb_gcd_controller;
  localparam int CNT_W = 8;
`ifdef GCD_TIMEOUT_EN
  localparam int MAXI = 8;
`else
  localparam int MAXI = 255;
`endif

  logic clk = 1'b0;
  logic rst, in_valid, out_ready, gt, lt, eq;
  logic in_ready, out_valid, busy, err, ldA, ldB, sel1, sel2, sel_in;
  logic [CNT_W-1:0] iter_cnt;
  logic [15:0] data_in, a_q, b_q, mn, sb, bus;
  int cyc = 0;
  int checks = 0;
  int failures = 0;

  gcd_controller #(.CNT_W(CNT_W), .MAX_ITER(MAXI)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .out_valid(out_valid), .out_ready(out_ready), .busy(busy), .err(err),
    .iter_cnt(iter_cnt), .gt(gt), .lt(lt), .eq(eq), .ldA(ldA), .ldB(ldB),
    .sel1(sel1), .sel2(sel2), .sel_in(sel_in)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Datapath harness: registers, subtractor, muxes and comparator.
  assign mn  = sel1 ? a_q : b_q;
  assign sb  = sel2 ? a_q : b_q;
  assign bus = sel_in ? data_in : mn - sb;
  assign gt  = a_q > b_q;
  assign lt  = a_q < b_q;
  assign eq  = a_q == b_q;
  always @(posedge clk) begin
    if (ldA) a_q <= bus;
    if (ldB) b_q <= bus;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Euclid by division: subtract steps = sum of quotients, minus the final equal step.
  function automatic void ref_gcd(input int a, input int b, output int g, output int n);
    int x, y, r;
    x = a; y = b; n = 0;
    while (y != 0) begin
      n += x / y;
      r = x % y;
      x = y;
      y = r;
    end
    g = x;
    n -= 1;
  endfunction

  task automatic run_op(input string tag, input int a, input int b, input int gap, input int hold);
    int g, n, t0, loads, k;
    ref_gcd(a, b, g, n);
    @(negedge clk); data_in = 16'(a); in_valid = 1'b1; #1;
    check({tag, " ldA"}, ldA, 1);
    check({tag, " idle_ready"}, in_ready, 1);
    t0 = cyc;
    for (int i = 0; i < gap; i++) begin
      @(negedge clk); in_valid = 1'b0; data_in = 16'($urandom); #1;
      check({tag, " hold_ldB"}, ldB, 0);
      check({tag, " hold_busy"}, busy, 1);
    end
    @(negedge clk); data_in = 16'(b); in_valid = 1'b1; #1;
    check({tag, " ldB"}, ldB, 1);
    @(negedge clk); in_valid = 1'b0; #1;
    loads = 0; k = 0;
    while (out_valid !== 1'b1 && k < 1000) begin
      if (ldA || ldB) loads++;
      @(negedge clk); #1; k++;
    end
    check({tag, " out_valid"}, out_valid, 1);
    check({tag, " latency"}, cyc - t0, n + 3 + gap);
    check({tag, " loads"}, loads, n);
    check({tag, " iter_cnt"}, iter_cnt, n);
    check({tag, " result"}, a_q, g);
    check({tag, " err"}, err, 0);
    for (int i = 0; i < hold; i++) begin
      check({tag, " stall_valid"}, out_valid, 1);
      check({tag, " stall_ready"}, in_ready, 0);
      check({tag, " stall_result"}, a_q, g);
      @(negedge clk); #1;
    end
    out_ready = 1'b1; in_valid = 1'b1; #1;
    check({tag, " hs_ready"}, in_ready, 0);
    check({tag, " hs_ldA"}, ldA, 0);
    @(negedge clk); out_ready = 1'b0; in_valid = 1'b0; #1;
    check({tag, " post_valid"}, out_valid, 0);
    check({tag, " post_busy"}, busy, 0);
    check({tag, " post_idle"}, in_ready, 1);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b1; out_ready = 1'b1; data_in = 16'd5;
    @(negedge clk); #1;
    check("rst in_ready", in_ready, 0);
    check("rst ldA", ldA, 0);
    check("rst sel_in", sel_in, 0);
    check("rst busy", busy, 0);
    check("rst out_valid", out_valid, 0);
    check("rst iter_cnt", iter_cnt, 0);
    @(negedge clk); rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0; #1;
    check("idle in_ready", in_ready, 1);
    check("idle busy", busy, 0);

    run_op("T1", 48, 18, 0, 0);
    run_op("T2", 7, 7, 0, 0);
    run_op("T3", 5, 35, 2, 0);
    run_op("T4", 12, 8, 0, 3);
    for (int i = 0; i < 8; i++)
      run_op("RND", int'($urandom_range(200, 1)), int'($urandom_range(200, 1)),
             int'($urandom_range(2, 0)), int'($urandom_range(3, 0)));

    // T5: reset in the middle of a long computation
    @(negedge clk); data_in = 16'd1000; in_valid = 1'b1;
    @(negedge clk); data_in = 16'd3;
    @(negedge clk); in_valid = 1'b0;
    repeat (10) @(negedge clk);
    rst = 1'b1; #1;
    check("T5 rst busy", busy, 0);
    check("T5 rst ldA", ldA, 0);
    check("T5 rst ldB", ldB, 0);
    check("T5 rst sel1", sel1, 0);
    check("T5 rst sel2", sel2, 0);
    check("T5 rst iter_cnt", iter_cnt, 0);
    check("T5 rst out_valid", out_valid, 0);
    @(negedge clk); rst = 1'b0; #1;
    check("T5 idle", in_ready, 1);
    check("T5 not busy", busy, 0);
    repeat (5) begin
      @(negedge clk); #1;
      check("T5 no out_valid", out_valid, 0);
    end
    run_op("T5b", 100, 75, 0, 1);

    // T6: zero operand
    @(negedge clk); data_in = 16'd0; in_valid = 1'b1;
    @(negedge clk); data_in = 16'd5;
    @(negedge clk); in_valid = 1'b0;
`ifdef GCD_TIMEOUT_EN
    begin
      int k;
      k = 0;
      #1;
      while (out_valid !== 1'b1 && k < 100) begin
        @(negedge clk); #1; k++;
      end
      check("T6 out_valid", out_valid, 1);
      check("T6 err", err, 1);
      check("T6 iter_cnt", iter_cnt, MAXI);
      check("T6 cycles", k, MAXI + 1);
      out_ready = 1'b1;
      @(negedge clk); out_ready = 1'b0; #1;
      check("T6 err cleared", err, 0);
      check("T6 idle", in_ready, 1);
    end
`else
    for (int i = 0; i < 300; i++) begin
      #1;
      if (i < 200) begin
        check("T6 busy", busy, 1);
        check("T6 out_valid", out_valid, 0);
      end
      @(negedge clk);
    end
    #1;
    check("T6 saturated", iter_cnt, 255);
    check("T6 err", err, 0);
    rst = 1'b1;
    @(negedge clk); rst = 1'b0; #1;
    check("T6 idle", in_ready, 1);
`endif
    run_op("T7", 21, 14, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
